// File: rtl/bat_input.sv
`timescale 1ns/1ps
// ============================================================================
// bat_input
// ----------------------------------------------------------------------------
// Human input front end for one tennis bat. Two push-buttons and a quadrature
// paddle encoder are turned into a signed per-frame bat displacement and a
// human/autoplayer select flag. Both outputs are refreshed once per frame, on
// the rising edge of the game's active-low vsync, and held for the whole frame.
//
// Parameters
//   IDLE_FRAMES : idle frames before control reverts to the autoplayer (1..1023)
//   MAX_SPEED   : button speed ceiling in lines/frame (1..15)
//   ENC_GAIN    : left shift applied to the encoder count (0 or 1)
//
// Ports
//   glb_clk    in  : system clock
//   reset_n    in  : asynchronous active-low reset
//   vsync      in  : game vsync, active-low, asynchronous
//   btn_up     in  : up button, active-high, debounced, asynchronous
//   btn_down   in  : down button, active-high, debounced, asynchronous
//   enc_a      in  : encoder phase A, asynchronous
//   enc_b      in  : encoder phase B, asynchronous
//   move       out : signed displacement, positive moves the bat up
//   human      out : 1 when the bat is under human control
//   frame_tick out : one-cycle pulse per detected vsync rising edge
// ============================================================================
module bat_input #(
    parameter int IDLE_FRAMES = 500,
    parameter int MAX_SPEED   = 8,
    parameter int ENC_GAIN    = 1
) (
    input  logic              glb_clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              enc_a,
    input  logic              enc_b,
    output logic signed [8:0] move,
    output logic              human,
    output logic              frame_tick
);

    localparam logic [9:0] IDLE_LIMIT  = 10'(IDLE_FRAMES);
    localparam logic [3:0] SPEED_LIMIT = 4'(MAX_SPEED);

    // Synchroniser chain, bit order {vsync, btn_up, btn_down, enc_a, enc_b}
    logic [4:0]        meta_q, meta_d;
    logic [4:0]        sync_q, sync_d;

    logic              vsync_dly_q, vsync_dly_d;
    logic [1:0]        enc_prev_q, enc_prev_d;
    logic signed [7:0] enc_acc_q, enc_acc_d;
    logic              act_q, act_d;
    logic [3:0]        speed_q, speed_d;
    logic [9:0]        idle_cnt_q, idle_cnt_d;
    logic              human_q, human_d;
    logic signed [8:0] move_q, move_d;

    logic              vsync_s;
    logic              up_s;
    logic              down_s;
    logic [1:0]        enc_s;

    assign {vsync_s, up_s, down_s, enc_s} = sync_q;

    assign frame_tick = vsync_s & ~vsync_dly_q;
    assign move       = move_q;
    assign human      = human_q;

    // Quadrature step: map {A,B} onto its position in the Gray cycle
    // 00,01,11,10 so that the modulo-4 difference of two positions gives
    // +1 (forward), 3 (reverse) or 0/2 (no change / illegal jump).
    logic [1:0]        pos_new;
    logic [1:0]        pos_old;
    logic [1:0]        pos_diff;
    logic signed [8:0] step;

    always_comb begin
        pos_new  = {enc_s[1], enc_s[1] ^ enc_s[0]};
        pos_old  = {enc_prev_q[1], enc_prev_q[1] ^ enc_prev_q[0]};
        pos_diff = pos_new - pos_old;
        step     = 9'sd0;
        case (pos_diff)
            2'd1:    step = 9'sd1;
            2'd3:    step = -9'sd1;
            default: step = 9'sd0;
        endcase
    end

    // Frame accumulator. On a tick the old frame's count is consumed by the
    // sum below, so the accumulator restarts from zero but still absorbs a
    // step arriving in that same cycle.
    logic signed [8:0] acc_base;
    logic signed [8:0] acc_sum;
    logic signed [7:0] acc_next;

    always_comb begin
        acc_base = frame_tick ? 9'sd0 : {enc_acc_q[7], enc_acc_q};
        acc_sum  = acc_base + step;
        if (acc_sum > 9'sd127) begin
            acc_next = 8'sd127;
        end else if (acc_sum < -9'sd128) begin
            acc_next = -8'sd128;
        end else begin
            acc_next = acc_sum[7:0];
        end
    end

    // Per-frame move computation: button speed ramp, scaled encoder count,
    // 10-bit sum clamped to the symmetric 9-bit range.
    logic              one_btn;
    logic [3:0]        speed_next;
    logic signed [9:0] btn_mag;
    logic signed [9:0] btn_term;
    logic signed [9:0] acc_ext;
    logic signed [9:0] acc_scaled;
    logic signed [9:0] sum_raw;
    logic signed [8:0] sum_clamped;
    logic              activity;
    logic [10:0]       idle_inc;

    always_comb begin
        one_btn = up_s ^ down_s;
        if (!one_btn) begin
            speed_next = 4'd0;
        end else if (speed_q >= SPEED_LIMIT) begin
            speed_next = SPEED_LIMIT;
        end else begin
            speed_next = speed_q + 4'd1;
        end

        btn_mag = signed'({6'd0, speed_next});
        if (up_s && !down_s) begin
            btn_term = btn_mag;
        end else if (down_s && !up_s) begin
            btn_term = -btn_mag;
        end else begin
            btn_term = 10'sd0;
        end

        acc_ext    = {{2{enc_acc_q[7]}}, enc_acc_q};
        acc_scaled = acc_ext <<< ENC_GAIN;
        sum_raw    = acc_scaled + btn_term;
        if (sum_raw > 10'sd255) begin
            sum_clamped = 9'sd255;
        end else if (sum_raw < -10'sd255) begin
            sum_clamped = -9'sd255;
        end else begin
            sum_clamped = sum_raw[8:0];
        end

        activity = act_q | one_btn | (btn_term != 10'sd0);
        idle_inc = {1'b0, idle_cnt_q} + 11'd1;
    end

    // Next-state for everything that only moves on a frame tick. Activity in
    // the expiring frame is tested first so it always keeps human control.
    always_comb begin
        meta_d      = {vsync, btn_up, btn_down, enc_a, enc_b};
        sync_d      = meta_q;
        vsync_dly_d = vsync_s;
        enc_prev_d  = enc_s;
        enc_acc_d   = acc_next;
        act_d       = act_q | (step != 9'sd0);
        speed_d     = speed_q;
        idle_cnt_d  = idle_cnt_q;
        human_d     = human_q;
        move_d      = move_q;

        if (frame_tick) begin
            act_d   = (step != 9'sd0);
            speed_d = speed_next;
            if (activity) begin
                idle_cnt_d = 10'd0;
                human_d    = 1'b1;
            end else begin
                if (idle_inc >= {1'b0, IDLE_LIMIT}) begin
                    idle_cnt_d = IDLE_LIMIT;
                    human_d    = 1'b0;
                end else begin
                    idle_cnt_d = idle_inc[9:0];
                end
            end
            move_d = human_d ? sum_clamped : 9'sd0;
        end
    end

    // State registers. Reset discards any partial frame and loads the idle
    // counter as already expired, so the bat starts under autoplayer control.
    always_ff @(posedge glb_clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q      <= 5'd0;
            sync_q      <= 5'd0;
            vsync_dly_q <= 1'b0;
            enc_prev_q  <= 2'd0;
            enc_acc_q   <= 8'sd0;
            act_q       <= 1'b0;
            speed_q     <= 4'd0;
            idle_cnt_q  <= IDLE_LIMIT;
            human_q     <= 1'b0;
            move_q      <= 9'sd0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            vsync_dly_q <= vsync_dly_d;
            enc_prev_q  <= enc_prev_d;
            enc_acc_q   <= enc_acc_d;
            act_q       <= act_d;
            speed_q     <= speed_d;
            idle_cnt_q  <= idle_cnt_d;
            human_q     <= human_d;
            move_q      <= move_d;
        end
    end

endmodule

// File: tb/tb_bat_input.sv
`timescale 1ns/1ps
// ============================================================================
// tb_bat_input
// ----------------------------------------------------------------------------
// Drives whole frames of button and encoder activity into bat_input and
// compares move/human/frame_tick against a frame-level model of the bat rules.
// ============================================================================
module tb_bat_input;

    localparam int IDLE_FRAMES = 4;
    localparam int MAX_SPEED   = 8;
    localparam int ENC_GAIN    = 1;

    logic              glb_clk  = 1'b0;
    logic              reset_n  = 1'b1;
    logic              vsync    = 1'b0;
    logic              btn_up   = 1'b0;
    logic              btn_down = 1'b0;
    logic              enc_a    = 1'b0;
    logic              enc_b    = 1'b0;
    logic signed [8:0] move;
    logic              human;
    logic              frame_tick;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    // Frame-level reference state
    int m_acc;
    int m_act;
    int m_speed;
    int m_idle;
    int m_human;
    int m_move;
    int m_carry;

    bat_input #(
        .IDLE_FRAMES(IDLE_FRAMES),
        .MAX_SPEED  (MAX_SPEED),
        .ENC_GAIN   (ENC_GAIN)
    ) dut (
        .glb_clk   (glb_clk),
        .reset_n   (reset_n),
        .vsync     (vsync),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .move      (move),
        .human     (human),
        .frame_tick(frame_tick)
    );

    // 100 MHz clock; inputs change and outputs are sampled on the falling edge
    always #5 glb_clk = ~glb_clk;

    // Hard stop in case the run ever runs away
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge glb_clk);
    endtask

    // Move the paddle one quadrature position along 00,01,11,10
    task automatic driveEnc(input int dir);
        phase = (phase + dir + 4) % 4;
        case (phase)
            0:       {enc_a, enc_b} = 2'b00;
            1:       {enc_a, enc_b} = 2'b01;
            2:       {enc_a, enc_b} = 2'b11;
            default: {enc_a, enc_b} = 2'b10;
        endcase
    endtask

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic modelReset();
        m_acc   = 0;
        m_act   = 0;
        m_speed = 0;
        m_idle  = IDLE_FRAMES;
        m_human = 0;
        m_move  = 0;
        m_carry = 0;
    endtask

    task automatic modelStep(input int dir);
        m_acc = clampInt(m_acc + dir, -128, 127);
        m_act = 1;
    endtask

    // One frame boundary, straight from the bat rules
    task automatic modelTick(input bit up, input bit down);
        int one;
        int bterm;
        int sum;
        one     = (up != down) ? 1 : 0;
        m_speed = one ? ((m_speed + 1 > MAX_SPEED) ? MAX_SPEED : m_speed + 1) : 0;
        if (up && !down)      bterm = m_speed;
        else if (down && !up) bterm = -m_speed;
        else                  bterm = 0;
        sum = clampInt(m_acc * (1 << ENC_GAIN) + bterm, -255, 255);
        if (m_act != 0 || one != 0 || bterm != 0) begin
            m_idle  = 0;
            m_human = 1;
        end else begin
            if (m_idle + 1 >= IDLE_FRAMES) m_human = 0;
            m_idle = (m_idle + 1 > IDLE_FRAMES) ? IDLE_FRAMES : m_idle + 1;
        end
        m_move  = m_human ? sum : 0;
        m_acc   = m_carry;
        m_act   = (m_carry != 0) ? 1 : 0;
        m_carry = 0;
    endtask

    // One full frame: hold buttons, run encoder steps, then a vsync pulse.
    // With coincident set, one extra forward step lands on the tick cycle.
    task automatic applyStimulus(input bit up, input bit down, input int n_fwd, input int n_rev,
                                 input bit mix, input bit coincident, input string tag);
        int fwd_left;
        int rev_left;
        int dir;
        int prev_move;
        fwd_left = n_fwd;
        rev_left = n_rev;
        btn_up   = up;
        btn_down = down;
        waitCycles(4);
        while (fwd_left + rev_left > 0) begin
            if (rev_left == 0)      dir = 1;
            else if (fwd_left == 0) dir = -1;
            else if (mix)           dir = (int'($urandom_range(fwd_left + rev_left - 1)) < fwd_left) ? 1 : -1;
            else                    dir = 1;
            if (dir > 0) fwd_left--; else rev_left--;
            driveEnc(dir);
            modelStep(dir);
            waitCycles(4);
        end
        waitCycles(4);
        vsync = 1'b0;
        waitCycles(4);
        prev_move = m_move;
        vsync     = 1'b1;
        if (coincident) begin
            driveEnc(1);
            m_carry = 1;
        end
        modelTick(up, down);
        waitCycles(1);
        checkOutput({tag, "_tick_early"}, int'(frame_tick), 0);
        waitCycles(1);
        checkOutput({tag, "_tick"}, int'(frame_tick), 1);
        checkOutput({tag, "_move_hold"}, int'(move), prev_move);
        waitCycles(1);
        checkOutput({tag, "_tick_end"}, int'(frame_tick), 0);
        checkOutput({tag, "_move"}, int'(move), m_move);
        checkOutput({tag, "_human"}, int'(human), m_human);
    endtask

    initial begin
        bit r_up;
        bit r_down;
        bit r_coin;
        modelReset();

        // Reset held with inputs toggling
        $display("[TB] reset");
        #1 reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            {vsync, btn_up, btn_down, enc_a, enc_b} = 5'($urandom);
            waitCycles(1);
            checkOutput("rst_move", int'(move), 0);
            checkOutput("rst_human", int'(human), 0);
            checkOutput("rst_tick", int'(frame_tick), 0);
        end
        {vsync, btn_up, btn_down, enc_a, enc_b} = 5'b0;
        phase = 0;
        waitCycles(3);
        reset_n = 1'b1;
        waitCycles(3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, "idle_start");

        // Button ramp, release, both buttons
        $display("[TB] buttons");
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 0, "ramp");
        applyStimulus(0, 0, 0, 0, 0, 0, "release");
        applyStimulus(1, 1, 0, 0, 0, 0, "both");

        // Encoder paths
        $display("[TB] encoder");
        applyStimulus(0, 0, 20, 0, 0, 0, "enc_fwd20");
        applyStimulus(0, 0, 0, 200, 0, 0, "enc_rev200");
        applyStimulus(0, 0, 3, 0, 0, 1, "enc_coin");
        applyStimulus(0, 0, 0, 0, 0, 0, "enc_coin_next");

        // Encoder plus down button at speed 3
        $display("[TB] combined");
        applyStimulus(0, 1, 0, 0, 0, 0, "comb_s1");
        applyStimulus(0, 1, 0, 0, 0, 0, "comb_s2");
        applyStimulus(0, 1, 10, 0, 0, 0, "comb_s3");

        // Idle timeout, then activity landing on the expiring frame
        $display("[TB] idle timeout");
        applyStimulus(1, 0, 0, 0, 0, 0, "to_act");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, "to_idle");
        applyStimulus(0, 0, 2, 0, 0, 0, "keep_act");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, "keep_idle");
        applyStimulus(0, 0, 1, 0, 0, 0, "keep_last");
        applyStimulus(0, 0, 0, 0, 0, 0, "keep_after");

        // Randomised frames
        $display("[TB] random");
        for (int f = 0; f < 30; f++) begin
            r_coin = ($urandom_range(3) == 0);
            if ($urandom_range(2) == 0) begin
                applyStimulus(0, 0, 0, 0, 1, r_coin, "rnd_idle");
            end else begin
                r_up   = 1'($urandom_range(1));
                r_down = ($urandom_range(3) == 0);
                applyStimulus(r_up, r_down, int'($urandom_range(40)), int'($urandom_range(40)),
                              1, r_coin, "rnd");
            end
        end

        // Asynchronous reset in the middle of a frame with a partial count
        $display("[TB] mid-frame reset");
        applyStimulus(1, 0, (6 - phase) % 4, 0, 0, 0, "align");
        btn_up = 1'b0;
        waitCycles(4);
        for (int i = 0; i < 50; i++) begin
            driveEnc(1);
            waitCycles(4);
        end
        waitCycles(4);
        #2 reset_n = 1'b0;
        #0.5;
        checkOutput("mid_rst_move", int'(move), 0);
        checkOutput("mid_rst_human", int'(human), 0);
        checkOutput("mid_rst_tick", int'(frame_tick), 0);
        #0.5 reset_n = 1'b1;
        // Idle inputs at release: any tick the resynchronised vsync produces
        // leaves the freshly reset state unchanged.
        modelReset();
        waitCycles(6);
        applyStimulus(0, 0, 0, 0, 0, 0, "post_rst");
        applyStimulus(1, 0, 0, 0, 0, 0, "post_rst_btn");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bat_input.md
# bat_input

Per-bat human input front end that sits directly upstream of the tennis game core. It converts two push-buttons and a quadrature paddle encoder into the signed per-frame bat displacement (`*bat_move`) and the human/auto select flag (`*bat_human`). The game core consumes both. One instance is used per bat. The move word is refreshed once per frame, on the rising edge of the game's active-low vsync, and is held stable for the whole frame.

## Interface
- `IDLE_FRAMES`, default 500: frames with no activity before control reverts to autoplayer (≈10 s at 50 Hz); range 1..1023.
- `MAX_SPEED`, default 8: button-driven speed ceiling in lines/frame; range 1..15.
- `ENC_GAIN`, default 1: left shift applied to the encoder count; 0 or 1.
- `glb_clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vsync` in 1: game vsync, active-low, asynchronous to this block's logic.
- `btn_up` in 1: active-high up button, asynchronous and already debounced.
- `btn_down` in 1: active-high down button, asynchronous and already debounced.
- `enc_a` in 1: quadrature encoder phase A, asynchronous.
- `enc_b` in 1: quadrature encoder phase B, asynchronous.
- `move` out 9: signed two's-complement displacement; positive moves the bat up (the consumer subtracts it from the bat y position).
- `human` out 1: 1 means the bat is under human control.
- `frame_tick` out 1: one-cycle pulse on each detected vsync rising edge.

## Operation
- **Synchronisers.** `vsync`, `btn_up`, `btn_down`, `enc_a` and `enc_b` each pass through a 2-flop synchroniser. All logic below uses only the synchronised copies.
- **Frame tick.** `frame_tick` = synchronised vsync high AND its one-cycle-delayed copy low.
- **Quadrature decoder.**
  - The {A,B} sequence 00→01→11→10→00 counts +1 (up).
  - The reverse sequence counts −1.
  - A two-bit change (illegal) or no change counts 0.
  - Counts accumulate into `enc_acc`, 8-bit signed, saturating at +127 and −128.
- **Button speed state** (`speed`, 4 bits), evaluated on each frame tick:
  - Exactly one button held: `speed` = min(`speed`+1, `MAX_SPEED`), so it reaches 1 on the first held frame.
  - No button or both buttons held: `speed` = 0.
  - Direction: `btn_up` gives +`speed`, `btn_down` gives −`speed`.
- **Activity flag** (`act`), set during the frame by either of:
  - any non-zero decoder step;
  - exactly one button sampled pressed at the tick.
  - Both buttons pressed is not activity.
- **On frame tick, all registers update in one cycle:**
  - `sum` = (`enc_acc` << `ENC_GAIN`) + button term, computed at 10-bit signed width, then clamped to −255..+255.
  - `move` = `human_next` ? `sum` : 0.
  - `enc_acc` cleared. A decoder step coincident with the tick is counted into the new frame, not lost.
  - `act` cleared.
  - If `act` is set or the button term is non-zero: `idle_cnt` = 0 and `human_next` = 1.
  - Otherwise: `idle_cnt` = min(`idle_cnt`+1, `IDLE_FRAMES`), and `human_next` = 0 when `idle_cnt`+1 ≥ `IDLE_FRAMES`, else unchanged.
  - `human` takes `human_next`.
- **Simultaneous events.** If activity occurs in the frame whose tick would expire the idle count, activity wins: `human` stays 1.
- **Reset** (asynchronous assert, synchronous-to-clock deassert via the existing reset tree):
  - `move` = 0, `human` = 0, `frame_tick` = 0;
  - `speed` = 0, `enc_acc` = 0, `act` = 0;
  - `idle_cnt` = `IDLE_FRAMES`, synchroniser flops = 0.
- **Reset mid-frame.** The partial `enc_acc` count is discarded. The first tick after release computes from post-reset inputs only.

## Timing
- The `vsync` rising edge at the pin reaches `frame_tick` high after 2 `glb_clk` edges. `move` and `human` update on the 3rd edge.
- `move` and `human` change only on a `frame_tick` cycle and are constant for the rest of the frame. The game core therefore samples a value that is stable across its own end-of-frame update; the one-frame input lag is accepted.
- Encoder edges must be at least 3 `glb_clk` cycles apart to be decoded. Faster edges may be seen as illegal transitions and dropped.
- There is no handshake: the consumer samples `move` at will.

## Test plan
- **Reset:** hold `reset_n`=0, toggle all inputs → `move`=0, `human`=0, `frame_tick`=0. Release, run 3 frames with inputs idle → `move`=0, `human`=0.
- **Button ramp:** hold `btn_up` for 10 frames (`MAX_SPEED`=8) → `move` sequence +1,+2,…,+8,+8,+8 and `human`=1 from the first tick. Release → next tick `move`=0. Press both buttons → `move`=0 and no activity counted.
- **Encoder:** 20 forward quadrature steps in one frame (`ENC_GAIN`=1) → `move`=+40. 200 reverse steps → `enc_acc` saturates at −128, so `move`=−255 after the clamp. Check the coincident step with a step on the tick cycle → it appears in the next frame.
- **Combined sum:** 10 forward steps plus `btn_down` at speed 3 → `move`=+17.
- **Idle timeout** (`IDLE_FRAMES`=4): one activity frame, then idle → `human`=1 for ticks 1–3 after the activity, 0 at tick 4, with `move`=0 from then on. Repeat with activity in the 4th frame → `human` stays 1.
- **Async reset mid-frame:** with `enc_acc`=+50, pulse `reset_n` low for 1 ns off the clock edge → outputs clear immediately, and the next tick gives `move`=0.
